seg_display_scanner: RTL and testbench
======================================

# seg_display_scanner

Hardware scan driver for the 4-digit seven-segment display on the peripheral bus. It consumes the value software writes to the digit-display register (0x4000_0010) and produces multiplexed, active-low anode and segment lines. It replaces software digit scanning with:
- a pending/shadow double buffer that updates only at frame boundaries, so there is no tearing;
- leading-zero blanking;
- PWM brightness control.

## Interface

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot. Must be a multiple of 16 and at least 16.

Ports (reset is synchronous, active-high; single clock domain):
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe for the display register. The bus asserts it for one cycle on MemWrite to 0x4000_0010.
- wr_data  in  32  register value, laid out as follows:
  - [15:0]: hex digits, digit0 = [3:0] … digit3 = [15:12].
  - [19:16]: decimal point per digit.
  - [23:20]: digit enable mask.
  - [24]: leading-zero-blank enable.
  - [27:25]: ignored.
  - [31:28]: brightness.
- cfg_q  out  32  current shadow (displayed) register; bits [27:25] read as 0.
- an  out  4  anodes, active-low; an[i] selects digit i.
- seg  out  8  segments, active-low; seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation

- **State:**
  - pending register plus pend_valid flag;
  - shadow register;
  - div_cnt, range 0..CLK_DIV-1;
  - digit index dig, 2 bits.
- **Write:** wr_en loads pending and sets pend_valid. Multiple writes within a frame: the last one wins.
- **Slot advance:** div_cnt increments every cycle. When div_cnt == CLK_DIV-1, it wraps to 0 and dig increments, wrapping 3→0.
- **Frame boundary:** the cycle where div_cnt == CLK_DIV-1 and dig == 3. On that edge:
  - if pend_valid, shadow ← pending and pend_valid is cleared;
  - frame_done is asserted the following cycle, aligned with dig == 0 and div_cnt == 0.
- **Write on the boundary cycle:** wr_data bypasses pending and loads shadow directly; pend_valid ends at 0.
- **Digit visibility:** digit d is lit iff all of the following hold:
  - mask[d] = 1;
  - it is not blanked;
  - the PWM condition div_cnt[3:0] ≤ brightness holds. This gives duty (b+1)/16; b = 15 is always on.
- **Leading-zero blanking:** when bit 24 is set, digit d (d = 3, 2, 1) is blanked if its nibble and all higher-digit nibbles are 0. Digit 0 is never blanked by this rule.
- **Outputs:**
  - an = ~(onehot(dig) & lit).
  - When the selected digit is lit, seg = {~dp[dig], hexdec(nibble[dig])}. When it is not lit, seg = 8'hFF.
- **hexdec, active-low g..a:**

  | Digit | Code | Digit | Code |
  |---|---|---|---|
  | 0 | 40 | 8 | 00 |
  | 1 | 79 | 9 | 10 |
  | 2 | 24 | A | 08 |
  | 3 | 30 | b | 03 |
  | 4 | 19 | C | 46 |
  | 5 | 12 | d | 21 |
  | 6 | 02 | E | 06 |
  | 7 | 78 | F | 0E |

## Timing

- **Reset values:**
  - an = 4'hF, seg = 8'hFF, frame_done = 0, cfg_q = 0;
  - pending = 0, pend_valid = 0, div_cnt = 0, dig = 0.
  - The display is dark after reset (mask = 0).
- **Registered outputs:** an and seg are registered, one cycle behind the (dig, div_cnt) state that produces them.
- **Write-to-visible latency:** the new value becomes visible at the next frame boundary, at most 4·CLK_DIV cycles after the write. cfg_q changes on the same edge as shadow.
- **Frame period:** exactly 4·CLK_DIV cycles. frame_done pulses exactly once per frame.
- **Reset mid-frame:** all state returns to reset values on that edge and any pending write is discarded. The first frame_done after reset release occurs 4·CLK_DIV cycles later.
- **Simultaneous wr_en and reset:** reset wins.

## Test plan

1. **Basic digit decode.** CLK_DIV = 32. Reset, then write 0xF0F0_1234. Required response:
   - no change before the first frame boundary;
   - after it, cfg_q = 0xF0F0_1234 and, per slot, an/seg = E/99, D/B0, B/A4, 7/F9 for digits 0..3;
   - frame_done pulses every 128 cycles.
2. **Leading-zero blank with dp.** Write 0xF1F1_0005, which sets blank, all digits enabled, dp on digit 0. Required response:
   - digit 0 shows an = E, seg = 0x12 (dp on);
   - digits 1–3 show an bit high and seg = FF.
3. **Brightness.** Write 0x30F0_8888 (brightness 3). Required response:
   - within each slot the anode is low exactly when div_cnt[3:0] ≤ 3, i.e. 8 of 32 cycles;
   - seg = 0x80 while lit.
4. **Back-to-back writes and boundary bypass.**
   - Write A, then B mid-frame: only B appears; A is never displayed.
   - Write C exactly on the boundary cycle: C is loaded that edge and pend_valid = 0.
5. **Reset mid-frame.** Write, then assert reset for 1 cycle before the boundary. Required response:
   - an = F, seg = FF, cfg_q = 0 afterwards;
   - the pending value never appears;
   - the first frame_done is 128 cycles after reset release.

Source files
------------

// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Scan driver for a 4-digit, common-anode seven-segment display. It takes
//   the digit-display register value from the bus and drives multiplexed,
//   active-low anode and segment lines. It provides:
//     - a pending/shadow double buffer that updates only at frame boundaries,
//       so the display never tears;
//     - leading-zero blanking;
//     - 16-level PWM brightness.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   wr_en      one-cycle write strobe for the display register
//   wr_data    register value:
//                [15:0]  hex digits
//                [19:16] decimal points
//                [23:20] digit enable mask
//                [24]    leading-zero blank enable
//                [31:28] brightness
//   cfg_q      currently displayed (shadow) register; bits [27:25] read 0
//   an         anodes, active-low, an[i] = digit i
//   seg        segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_done one-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
module seg_display_scanner #(
   parameter int CLK_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [31:0] cfg_q,
   output logic [3:0]  an,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
   // Bits [27:25] are unused and always stored as zero.
   localparam logic [31:0]      CFG_MASK = 32'hF1FF_FFFF;

   logic [31:0]      pending;
   logic             pend_valid;
   logic [31:0]      shadow;
   logic [CNT_W-1:0] div_cnt;
   logic [1:0]       dig;

   logic             frame_end;
   logic [3:0]       mask;
   logic [3:0]       dp;
   logic [3:0]       blank;
   logic [3:0]       nib;
   logic             lit;
   logic [3:0]       an_p0;
   logic [7:0]       seg_p0;

   // Active-low g..a pattern for one hex digit.
   function automatic logic [6:0] hexdec(input logic [3:0] n);
      logic [6:0] code;
      case (n)
         4'h0: code = 7'h40;
         4'h1: code = 7'h79;
         4'h2: code = 7'h24;
         4'h3: code = 7'h30;
         4'h4: code = 7'h19;
         4'h5: code = 7'h12;
         4'h6: code = 7'h02;
         4'h7: code = 7'h78;
         4'h8: code = 7'h00;
         4'h9: code = 7'h10;
         4'hA: code = 7'h08;
         4'hB: code = 7'h03;
         4'hC: code = 7'h46;
         4'hD: code = 7'h21;
         4'hE: code = 7'h06;
         default: code = 7'h0E;
      endcase
      return code;
   endfunction

   // Stage p0: decode the currently selected digit from the shadow register.
   always_comb begin
      frame_end = (div_cnt == CNT_MAX) && (dig == 2'd3);
      mask      = shadow[23:20];
      dp        = shadow[19:16];

      // A digit is blanked only when it and every more significant digit
      // are zero; digit 0 always shows so a zero value still reads "0".
      blank = 4'b0000;
      if (shadow[24]) begin
         blank[3] = (shadow[15:12] == 4'h0);
         blank[2] = blank[3] && (shadow[11:8] == 4'h0);
         blank[1] = blank[2] && (shadow[7:4] == 4'h0);
      end

      case (dig)
         2'd0:    nib = shadow[3:0];
         2'd1:    nib = shadow[7:4];
         2'd2:    nib = shadow[11:8];
         default: nib = shadow[15:12];
      endcase

      // PWM: on for counter phases 0..brightness of every 16-cycle period.
      lit    = mask[dig] && !blank[dig] && (div_cnt[3:0] <= shadow[31:28]);
      an_p0  = lit ? ~(4'b0001 << dig) : 4'hF;
      seg_p0 = lit ? {~dp[dig], hexdec(nib)} : 8'hFF;
   end

   // Stage p1: registered outputs, scan counters and the double buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending    <= '0;
         pend_valid <= 1'b0;
         shadow     <= '0;
         div_cnt    <= '0;
         dig        <= 2'd0;
         an         <= 4'hF;
         seg        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         an         <= an_p0;
         seg        <= seg_p0;
         frame_done <= frame_end;

         if (div_cnt == CNT_MAX) begin
            div_cnt <= '0;
            dig     <= dig + 2'd1;
         end else begin
            div_cnt <= div_cnt + CNT_W'(1);
         end

         // A write landing on the boundary edge goes straight to the shadow
         // so it is not held back a whole frame.
         if (frame_end) begin
            pend_valid <= 1'b0;
            if (wr_en) begin
               shadow <= wr_data & CFG_MASK;
            end else if (pend_valid) begin
               shadow <= pending;
            end
         end else if (wr_en) begin
            pending    <= wr_data & CFG_MASK;
            pend_valid <= 1'b1;
         end
      end
   end

   assign cfg_q = shadow;

endmodule

// File: tb/tb_seg_display_scanner.sv
module tb_seg_display_scanner;

   localparam int CLK_DIV = 32;
   localparam int FRAME   = 4 * CLK_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = 32'h0;
   logic [31:0] cfg_q;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   seg_display_scanner #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .cfg_q      (cfg_q),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [31:0] wdata;
      logic [31:0] cfg;
      logic [15:0] an_exp;   // {d3,d2,d1,d0}
      logic [31:0] seg_exp;  // {d3,d2,d1,d0}
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Advance until frame_done is seen high (at least one cycle), bounded.
   task automatic wait_frame(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!frame_done && cyc < 300);
   endtask

   // One-cycle write; returns one cycle later.
   task automatic write_reg(input logic [31:0] v);
      wr_en   = 1'b1;
      wr_data = v;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          k;
      int          lit_cnt;
      logic [31:0] prev_cfg;
      logic [3:0]  exp_an;
      logic [7:0]  exp_seg;

      vecs[0] = '{32'hF0F0_1234, 32'hF0F0_1234, 16'h7BDE, 32'hF9A4_B099};
      vecs[1] = '{32'hF1F1_0005, 32'hF1F1_0005, 16'hFFFE, 32'hFFFF_FF12};
      vecs[2] = '{32'hFE3A_C0B0, 32'hF03A_C0B0, 16'hFFDE, 32'hFFFF_03C0};
      vecs[3] = '{32'hF1F0_0D0E, 32'hF1F0_0D0E, 16'hFBDE, 32'hFFA1_C086};
      vecs[4] = '{32'hF0F0_5678, 32'hF0F0_5678, 16'h7BDE, 32'h9282_F880};
      vecs[5] = '{32'hF0F0_9ABC, 32'hF0F0_9ABC, 16'h7BDE, 32'h9088_83C6};
      vecs[6] = '{32'hF0FF_DEF0, 32'hF0FF_DEF0, 16'h7BDE, 32'h2106_0E40};

      // Reset state
      step(3);
      check("reset_an", {28'h0, an}, 32'hF);
      check("reset_seg", {24'h0, seg}, 32'hFF);
      check("reset_frame_done", {31'h0, frame_done}, 32'h0);
      check("reset_cfg", cfg_q, 32'h0);
      reset = 1'b0;

      wait_frame(cyc);
      check("first_frame_after_reset", cyc, FRAME);
      check("dark_after_reset_an", {28'h0, an}, 32'hF);

      // Table-driven frames: write at frame start, check at next boundary
      prev_cfg = 32'h0;
      foreach (vecs[i]) begin
         write_reg(vecs[i].wdata);
         check($sformatf("v%0d_cfg_before_boundary", i), cfg_q, prev_cfg);
         wait_frame(cyc);
         check($sformatf("v%0d_latency", i), cyc, FRAME - 1);
         check($sformatf("v%0d_cfg", i), cfg_q, vecs[i].cfg);
         k = 0;
         for (int d = 0; d < 4; d++) begin
            step(32 * d + 1 - k);
            k = 32 * d + 1;
            check($sformatf("v%0d_an_d%0d", i, d), {28'h0, an}, {28'h0, vecs[i].an_exp[d*4 +: 4]});
            check($sformatf("v%0d_seg_d%0d", i, d), {24'h0, seg}, {24'h0, vecs[i].seg_exp[d*8 +: 8]});
         end
         wait_frame(cyc);
         check($sformatf("v%0d_frame_period_tail", i), cyc, FRAME - k);
         prev_cfg = vecs[i].cfg;
      end

      // Brightness 3: lit for div_cnt[3:0] <= 3 in each slot
      write_reg(32'h30F0_8888);
      wait_frame(cyc);
      check("bright_latency", cyc, FRAME - 1);
      lit_cnt = 0;
      for (int kk = 1; kk <= FRAME; kk++) begin
         step(1);
         if ((((kk - 1) % CLK_DIV) % 16) <= 3) begin
            exp_an  = ~(4'b0001 << ((kk - 1) / CLK_DIV));
            exp_seg = 8'h80;
         end else begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
         end
         if (an != 4'hF) lit_cnt++;
         check($sformatf("bright_k%0d", kk), {20'h0, an, seg}, {20'h0, exp_an, exp_seg});
      end
      check("bright_lit_cycles", lit_cnt, 32);
      check("bright_frame_done", {31'h0, frame_done}, 32'h1);

      // Back-to-back writes: only the last one is shown
      write_reg(32'hF0F0_AAAA);
      step(49);
      write_reg(32'hF0F0_BBBB);
      check("b2b_cfg_hold", cfg_q, 32'h30F0_8888);
      wait_frame(cyc);
      check("b2b_latency", cyc, FRAME - 51);
      check("b2b_cfg", cfg_q, 32'hF0F0_BBBB);
      step(1);
      check("b2b_seg_d0", {20'h0, an, seg}, {20'h0, 4'hE, 8'h83});

      // Boundary bypass: pending D is overridden by C written on the boundary
      step(59);
      write_reg(32'hF0F0_DDDD);
      step(66);
      write_reg(32'hF0F0_1111);
      check("bypass_frame_done", {31'h0, frame_done}, 32'h1);
      check("bypass_cfg", cfg_q, 32'hF0F0_1111);
      wait_frame(cyc);
      check("bypass_period", cyc, FRAME);
      check("bypass_pend_cleared", cfg_q, 32'hF0F0_1111);

      // Reset mid-frame, with a write coinciding with reset
      write_reg(32'hF0F0_EEEE);
      step(125);
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 32'hF0F0_7777;
      step(1);
      reset   = 1'b0;
      wr_en   = 1'b0;
      check("midrst_an", {28'h0, an}, 32'hF);
      check("midrst_seg", {24'h0, seg}, 32'hFF);
      check("midrst_cfg", cfg_q, 32'h0);
      wait_frame(cyc);
      check("midrst_first_frame", cyc, FRAME);
      check("midrst_cfg_after_frame", cfg_q, 32'h0);
      wait_frame(cyc);
      check("midrst_cfg_second_frame", cfg_q, 32'h0);
      check("midrst_dark", {28'h0, an}, 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
